// File: rtl/sseg_stopwatch.sv
// Centisecond stopwatch (0.00-99.99 s) feeding a four-digit seven-segment controller.
// Start/stop, lap and clear buttons arrive debounced and synchronous to clk.
module sseg_stopwatch #(
   parameter int unsigned TICK_DIV = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_stop,
   input  logic        lap,
   input  logic        clear,
   output logic [13:0] num,
   output logic [3:0]  dig_en,
   output logic [3:0]  dp_en,
   output logic        running
);

   localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CNT_W   = 14;
   localparam int unsigned CNT_MAX = 9999;
   localparam int unsigned LEAD_MIN = 1000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   lap_val;
   logic [PRE_W-1:0]   pre;
   logic               start_stop_q;
   logic               lap_q;
   logic               clear_q;
   logic               armed;
   logic               start_stop_e;
   logic               lap_e;
   logic               clear_e;
   logic               lap_load;
   logic               tick_en;
   logic               tick;

   // Rising-edge detect; the first cycle after reset only samples, so a level
   // already high during reset never counts as a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_stop_q <= 1'b0;
         lap_q        <= 1'b0;
         clear_q      <= 1'b0;
         armed        <= 1'b0;
      end else begin
         start_stop_q <= start_stop;
         lap_q        <= lap;
         clear_q      <= clear;
         armed        <= 1'b1;
      end
   end

   assign start_stop_e = armed & start_stop & ~start_stop_q;
   assign lap_e        = armed & lap & ~lap_q;
   assign clear_e      = armed & clear & ~clear_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: clear beats start_stop beats lap; losers are dropped
   always_comb begin
      state_nxt = state;
      lap_load  = 1'b0;
      if (clear_e) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_stop_e) state_nxt = RUN;
            end
            RUN: begin
               if (start_stop_e) begin
                  state_nxt = PAUSE;
               end else if (lap_e) begin
                  state_nxt = LAP;
                  lap_load  = 1'b1;
               end
            end
            LAP: begin
               if (start_stop_e) begin
                  state_nxt = PAUSE;
               end else if (lap_e) begin
                  state_nxt = RUN;
               end
            end
            PAUSE: begin
               if (start_stop_e) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign tick_en = (state == RUN) || (state == LAP);
   assign tick    = tick_en && (pre == PRE_W'(TICK_DIV - 1));

   // Prescaler, live count and frozen lap value
   always_ff @(posedge clk) begin
      if (rst || clear_e) begin
         pre     <= '0;
         count   <= '0;
         lap_val <= '0;
      end else begin
         if (tick_en) begin
            pre <= tick ? '0 : pre + PRE_W'(1);
         end
         if (tick) begin
            count <= (count == CNT_W'(CNT_MAX)) ? '0 : count + CNT_W'(1);
         end
         if (lap_load) begin
            lap_val <= count;
         end
      end
   end

   // Display outputs straight from the registers
   always_comb begin
      num     = count;
      running = 1'b0;
      dp_en   = 4'b0100;
      if (state == LAP) begin
         num = lap_val;
      end
      if (tick_en) begin
         running = 1'b1;
      end
      dig_en = {(num >= CNT_W'(LEAD_MIN)), 3'b111};
   end

endmodule

// File: doc/sseg_stopwatch.md
# sseg_stopwatch

Centisecond stopwatch that generates the display data for the board's four-digit seven-segment controller. It turns start/stop, lap and clear button inputs into a 0.00–99.99 s running count. It drives the controller's `num`, `dig_en` and `dp_en` inputs directly. Buttons arrive already debounced and synchronous to `clk`.

## Interface
- `TICK_DIV`, default 1000000: `clk` cycles per 0.01 s tick (100 MHz board clock). Must be ≥ 2.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous and active-high.
- `start_stop` input 1: debounced level. Its rising edge toggles run/stop.
- `lap` input 1: debounced level. Its rising edge freezes or releases the displayed value.
- `clear` input 1: debounced level. Its rising edge stops and zeroes the stopwatch.
- `num` output 14: displayed value in centiseconds, 0–9999.
- `dig_en` output 4: digit enables. Bit 0 is the rightmost digit.
- `dp_en` output 4: decimal-point enables. Bit 0 is the rightmost digit.
- `running` output 1: high while the count is advancing.

## Operation
- Edge detect: register each button once (`x_q`); the edge is `x & ~x_q`. A held level acts once only.
- Registers:
  - `count` [13:0], the live value.
  - `lap_val` [13:0], the frozen value.
  - `pre`, the prescaler, sized to hold `TICK_DIV-1`.
  - `state`.
- Prescaler: `pre` advances only in RUN or LAP. When `pre` is `TICK_DIV-1`, it returns to 0 and `count` increments on the same edge.
- `count` wraps from 9999 to 0. There is no flag and no stop at the wrap.
- States and transitions (edges only):
  - IDLE: `count`=0, `pre`=0. `start_stop` goes to RUN. `lap` is ignored.
  - RUN: `start_stop` goes to PAUSE. `lap` goes to LAP and loads `lap_val` with the current `count`.
  - LAP: `lap` goes to RUN. `start_stop` goes to PAUSE, and the display returns to live.
  - PAUSE: `start_stop` goes to RUN. `lap` is ignored. `pre` and `count` are held, so a partial tick resumes where it stopped.
- `clear` in any state goes to IDLE and zeroes `count`, `pre` and `lap_val`.
- Priority in the same cycle: `clear` > `start_stop` > `lap`. The lower-priority edges are discarded, not deferred.
- `num` is `lap_val` in LAP and `count` otherwise.
- `running` is 1 in RUN and LAP.
- `dig_en`: bits [2:0] are always 1, giving the "0.00" minimum. Bit 3 is `(num >= 1000)`, which blanks the leading zero.
- `dp_en` is constant 4'b0100: the point sits after digit 2, giving SS.hh.

## Timing
- Reset (at any time, including mid-count) values:
  - `state` IDLE; `count`, `pre`, `lap_val` and all `x_q` 0.
  - `num` 0, `dig_en` 4'b0111, `dp_en` 4'b0100, `running` 0.
- Button latency: if a button is low at edge k-1 and high at edge k, the state update happens at edge k. Outputs reflect it immediately after edge k.
- A button that is already high when `rst` deasserts does not count as an edge.
- First tick: after a `start_stop` edge at edge k from IDLE, `count` becomes 1 at edge k+`TICK_DIV`.
- `num`, `dig_en` and `running` are derived from registers with no additional pipeline stage. `num` changes on the edge where `count` or `state` changes.
- A `lap` release in LAP shows the live `count` from that edge onward. Ticks that occurred during LAP are already included in it.

## Test plan
All scenarios use `TICK_DIV`=4.
- Reset, then 20 idle cycles: `num`=0, `dig_en`=0111, `dp_en`=0100, `running`=0 throughout.
- Start pulse at edge k: `running`=1 at k, `num`=1 at k+4, `num`=N at k+4N. At the 999→1000 step, `dig_en` goes 0111→1111 on the same edge.
- Run 40000 cycles past start: `num` steps 9999→0, and `dig_en` returns to 0111 on the same edge.
- Stop two cycles after a tick (`pre`=2), then wait 50 cycles: `num` and `running`=0 are frozen. After restart at edge j, the next increment lands at edge j+2.
- Lap at `num`=25: `num` holds 25 while `running`=1. A second lap when the live `count` is 40 shows `num`=40 on that edge, then it increments normally.
- Priority and reset:
  - `clear` and `start_stop` rising together in RUN: IDLE, `num`=0, `running`=0.
  - `start_stop` held high for 10 cycles toggles exactly once.
  - `rst` asserted mid-RUN returns all outputs to their reset values on the next edge.
